// File: rtl/fg_dac_writer.sv
// Paces function-generator samples onto a parallel DAC: setup / WR-low / hold strobe per sample, one-entry pending buffer.
// Latency: 1 edge valid_i -> dac_data_o, SETUP_CYCLES more to WR fall; no backpressure, excess strobes overwrite pending and flag overrun.
module fg_dac_writer #(
  parameter int BITWIDTH      = 8,
  parameter int SETUP_CYCLES  = 1,
  parameter int WR_LOW_CYCLES = 2,
  parameter int HOLD_CYCLES   = 1,
  parameter int CLR_CYCLES    = 4
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                enable_i,
  input  logic [BITWIDTH-1:0] data_i,
  input  logic                valid_i,
  input  logic                ovr_clr_i,
  output logic [BITWIDTH-1:0] dac_data_o,
  output logic                dac_wr_n_o,
  output logic                dac_clr_n_o,
  output logic                dac_pd_n_o,
  output logic                busy_o,
  output logic                overrun_o,
  output logic [7:0]          wr_count_o
);

  localparam logic [2:0] ST_CLEAR = 3'd0;
  localparam logic [2:0] ST_IDLE  = 3'd1;
  localparam logic [2:0] ST_SETUP = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_HOLD  = 3'd4;

  localparam logic [3:0] CLR_LAST   = 4'(CLR_CYCLES - 1);
  localparam logic [3:0] SETUP_LAST = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] WR_LAST    = 4'(WR_LOW_CYCLES - 1);
  localparam logic [3:0] HOLD_LAST  = 4'(HOLD_CYCLES - 1);

  logic [2:0]          state, state_nxt;
  logic [3:0]          phase, phase_nxt;
  logic [BITWIDTH-1:0] pend_data;
  logic                pend_full;
  logic                strobe, active, hold_done, write_done, load_new, load_pend;

  assign strobe     = valid_i & enable_i;
  assign active     = (state == ST_SETUP) | (state == ST_WRITE) | (state == ST_HOLD);
  assign hold_done  = (state == ST_HOLD) & (phase == HOLD_LAST);
  assign write_done = (state == ST_WRITE) & (phase == WR_LAST);
  // A fresh strobe at the end of HOLD wins over whatever is pending.
  assign load_new   = strobe & ((state == ST_IDLE) | hold_done);
  assign load_pend  = hold_done & ~strobe & enable_i & pend_full;

  always_comb begin
    state_nxt = state;
    phase_nxt = phase + 4'd1;
    case (state)
      ST_CLEAR: if (phase == CLR_LAST) begin
        state_nxt = ST_IDLE;
        phase_nxt = 4'd0;
      end
      ST_IDLE: begin
        phase_nxt = 4'd0;
        if (strobe) state_nxt = ST_SETUP;
      end
      ST_SETUP: if (phase == SETUP_LAST) begin
        state_nxt = ST_WRITE;
        phase_nxt = 4'd0;
      end
      ST_WRITE: if (phase == WR_LAST) begin
        state_nxt = ST_HOLD;
        phase_nxt = 4'd0;
      end
      ST_HOLD: if (phase == HOLD_LAST) begin
        state_nxt = (load_new | load_pend) ? ST_SETUP : ST_IDLE;
        phase_nxt = 4'd0;
      end
      default: begin
        state_nxt = ST_CLEAR;
        phase_nxt = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state       <= ST_CLEAR;
      phase       <= 4'd0;
      dac_data_o  <= '0;
      dac_wr_n_o  <= 1'b1;
      dac_clr_n_o <= 1'b0;
      dac_pd_n_o  <= 1'b1;
      busy_o      <= 1'b1;
      overrun_o   <= 1'b0;
      wr_count_o  <= 8'd0;
      pend_data   <= '0;
      pend_full   <= 1'b0;
    end else begin
      state       <= state_nxt;
      phase       <= phase_nxt;
      // Strobe pins follow the next state so they change cleanly on the edge.
      dac_wr_n_o  <= (state_nxt != ST_WRITE);
      dac_clr_n_o <= (state_nxt != ST_CLEAR);
      busy_o      <= (state_nxt != ST_IDLE);
      dac_pd_n_o  <= ~(~enable_i & (state == ST_IDLE));

      if (load_new)       dac_data_o <= data_i;
      else if (load_pend) dac_data_o <= pend_data;

      if (!enable_i) begin
        pend_full <= 1'b0;
      end else if (active & strobe & ~hold_done) begin
        pend_data <= data_i;
        pend_full <= 1'b1;
      end else if (hold_done) begin
        pend_full <= 1'b0;
      end

      if (active & strobe & pend_full) overrun_o <= 1'b1;
      else if (ovr_clr_i)              overrun_o <= 1'b0;

      if (write_done) wr_count_o <= wr_count_o + 8'd1;
    end
  end

endmodule

// File: tb/tb_fg_dac_writer.sv
// Directed + random bench for fg_dac_writer against a write-position reference model.
module tb_fg_dac_writer;
  localparam int S = 1, W = 2, H = 1, C = 4, T = S + W + H;

  logic       clk_i = 1'b0;
  logic       rstn_i, enable_i, valid_i, ovr_clr_i;
  logic [7:0] data_i;
  logic [7:0] dac_data_o, wr_count_o;
  logic       dac_wr_n_o, dac_clr_n_o, dac_pd_n_o, busy_o, overrun_o;

  always #5 clk_i = ~clk_i;

  fg_dac_writer #(
    .BITWIDTH(8), .SETUP_CYCLES(S), .WR_LOW_CYCLES(W), .HOLD_CYCLES(H), .CLR_CYCLES(C)
  ) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .enable_i(enable_i), .data_i(data_i),
    .valid_i(valid_i), .ovr_clr_i(ovr_clr_i), .dac_data_o(dac_data_o),
    .dac_wr_n_o(dac_wr_n_o), .dac_clr_n_o(dac_clr_n_o), .dac_pd_n_o(dac_pd_n_o),
    .busy_o(busy_o), .overrun_o(overrun_o), .wr_count_o(wr_count_o)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a write is a position 0..T-1 in its strobe sequence, -1 when idle.
  bit         m_clear;
  int         m_clr_edges;
  int         m_pos;
  logic [7:0] m_data;
  logic [7:0] m_pend[$];
  bit         m_ovr;
  int         m_cnt;
  bit         m_pd_n;

  logic [7:0] wr_log[$];
  int         wr_edge[$];
  int         edge_no = 0;
  logic       prev_wr_n = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_clear = 1'b1; m_clr_edges = 0; m_pos = -1; m_data = 8'h00;
    m_pend.delete(); m_ovr = 1'b0; m_cnt = 0; m_pd_n = 1'b1;
  endtask

  task automatic model_edge();
    bit strobe, prev_idle, set_ovr;
    edge_no++;
    if (!rstn_i) begin
      model_reset();
      return;
    end
    strobe    = valid_i && enable_i;
    prev_idle = !m_clear && (m_pos < 0);
    set_ovr   = 1'b0;
    if (m_clear) begin
      m_clr_edges++;
      if (m_clr_edges == C) m_clear = 1'b0;
    end else if (m_pos < 0) begin
      if (strobe) begin m_data = data_i; m_pos = 0; end
    end else begin
      if (strobe && m_pend.size() > 0) set_ovr = 1'b1;
      if (m_pos == S + W - 1) m_cnt = (m_cnt + 1) % 256;
      if (m_pos == T - 1) begin
        if (strobe) begin m_data = data_i; m_pos = 0; end
        else if (enable_i && m_pend.size() > 0) begin m_data = m_pend[0]; m_pos = 0; end
        else m_pos = -1;
        m_pend.delete();
      end else begin
        m_pos++;
        if (strobe) begin m_pend.delete(); m_pend.push_back(data_i); end
      end
      if (!enable_i) m_pend.delete();
    end
    if (set_ovr) m_ovr = 1'b1;
    else if (ovr_clr_i) m_ovr = 1'b0;
    m_pd_n = !(!enable_i && prev_idle);
  endtask

  task automatic check_all();
    chk("dac_data", 32'(dac_data_o), 32'(m_data));
    chk("wr_n", 32'(dac_wr_n_o), 32'(!(m_pos >= S && m_pos < S + W)));
    chk("clr_n", 32'(dac_clr_n_o), 32'(!m_clear));
    chk("pd_n", 32'(dac_pd_n_o), 32'(m_pd_n));
    chk("busy", 32'(busy_o), 32'(m_clear || m_pos >= 0));
    chk("overrun", 32'(overrun_o), 32'(m_ovr));
    chk("wr_count", 32'(wr_count_o), 32'(m_cnt));
    if (prev_wr_n === 1'b1 && dac_wr_n_o === 1'b0) begin
      wr_log.push_back(dac_data_o);
      wr_edge.push_back(edge_no);
    end
    prev_wr_n = dac_wr_n_o;
  endtask

  task automatic step(input logic en, input logic vld, input logic [7:0] d, input logic oclr);
    enable_i = en; valid_i = vld; data_i = d; ovr_clr_i = oclr;
    @(posedge clk_i);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic clear_log();
    wr_log.delete();
    wr_edge.delete();
  endtask

  initial begin
    int rise;
    rstn_i = 1'b1; enable_i = 1'b0; valid_i = 1'b0; data_i = 8'h00; ovr_clr_i = 1'b0;
    #2 rstn_i = 1'b0;
    #1;
    model_reset();
    check_all();
    repeat (3) step(1'b0, 1'b0, 8'h00, 1'b0);

    // Reset release with a strobe in the second cycle: must be ignored.
    rstn_i = 1'b1;
    rise = 0;
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, i == 2, 8'h5A, 1'b0);
      if (rise == 0 && dac_clr_n_o === 1'b1) rise = i;
    end
    chk("clr_len", 32'(rise), 32'(C));
    chk("clr_count", 32'(wr_count_o), 32'd0);
    chk("clr_ignored", 32'(wr_log.size()), 32'd0);

    // Single write of 0xA5.
    clear_log();
    step(1'b1, 1'b1, 8'hA5, 1'b0);
    chk("a5_data_e1", 32'(dac_data_o), 32'hA5);
    chk("a5_wr_e1", 32'(dac_wr_n_o), 32'd1);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    chk("a5_wr_e2", 32'(dac_wr_n_o), 32'd0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    chk("a5_wr_e3", 32'(dac_wr_n_o), 32'd0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    chk("a5_wr_e4", 32'(dac_wr_n_o), 32'd1);
    chk("a5_count", 32'(wr_count_o), 32'd1);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    chk("a5_idle", 32'(busy_o), 32'd0);
    chk("a5_log_n", 32'(wr_log.size()), 32'd1);

    // Back-to-back: second strobe lands in the pending buffer.
    clear_log();
    step(1'b1, 1'b1, 8'h11, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b1, 8'h22, 1'b0);
    repeat (10) step(1'b1, 1'b0, 8'h00, 1'b0);
    chk("b2b_n", 32'(wr_log.size()), 32'd2);
    if (wr_log.size() == 2) begin
      chk("b2b_first", 32'(wr_log[0]), 32'h11);
      chk("b2b_second", 32'(wr_log[1]), 32'h22);
      chk("b2b_gap", 32'(wr_edge[1] - wr_edge[0]), 32'd4);
    end
    chk("b2b_ovr", 32'(overrun_o), 32'd0);
    chk("b2b_count", 32'(wr_count_o), 32'd3);

    // Overrun: the middle sample is overwritten.
    clear_log();
    step(1'b1, 1'b1, 8'h01, 1'b0);
    step(1'b1, 1'b1, 8'h02, 1'b0);
    step(1'b1, 1'b1, 8'h03, 1'b0);
    repeat (10) step(1'b1, 1'b0, 8'h00, 1'b0);
    chk("ovr_n", 32'(wr_log.size()), 32'd2);
    if (wr_log.size() == 2) begin
      chk("ovr_first", 32'(wr_log[0]), 32'h01);
      chk("ovr_second", 32'(wr_log[1]), 32'h03);
    end
    chk("ovr_sticky", 32'(overrun_o), 32'd1);
    step(1'b1, 1'b0, 8'h00, 1'b1);
    chk("ovr_cleared", 32'(overrun_o), 32'd0);

    // Disable during WRITE with 0x44 pending.
    clear_log();
    step(1'b1, 1'b1, 8'h33, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b1, 8'h44, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("dis_idle", 32'(busy_o), 32'd0);
    chk("dis_pd_lag", 32'(dac_pd_n_o), 32'd1);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("dis_pd", 32'(dac_pd_n_o), 32'd0);
    step(1'b0, 1'b1, 8'h55, 1'b0);
    repeat (6) step(1'b0, 1'b0, 8'h00, 1'b0);
    repeat (2) step(1'b1, 1'b0, 8'h00, 1'b0);
    chk("dis_n", 32'(wr_log.size()), 32'd1);
    if (wr_log.size() == 1) chk("dis_data", 32'(wr_log[0]), 32'h33);

    // Random traffic checked cycle by cycle against the model.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 9) != 0, $urandom_range(0, 2) == 0, 8'($urandom), $urandom_range(0, 19) == 0);
    repeat (8) step(1'b1, 1'b0, 8'h00, 1'b0);

    // Reset asserted in the middle of the WR-low phase.
    step(1'b1, 1'b1, 8'hC3, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    chk("mid_wr_low", 32'(dac_wr_n_o), 32'd0);
    #2 rstn_i = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_wr_n", 32'(dac_wr_n_o), 32'd1);
    check_all();
    repeat (2) step(1'b1, 1'b0, 8'h00, 1'b0);
    rstn_i = 1'b1;
    repeat (C + 2) step(1'b1, 1'b0, 8'h00, 1'b0);

    // 256 writes wrap the counter back to zero.
    clear_log();
    for (int i = 0; i < 256; i++) begin
      step(1'b1, 1'b1, 8'(i), 1'b0);
      repeat (3) step(1'b1, 1'b0, 8'h00, 1'b0);
    end
    repeat (6) step(1'b1, 1'b0, 8'h00, 1'b0);
    chk("wrap_count", 32'(wr_count_o), 32'd0);
    chk("wrap_n", 32'(wr_log.size()), 32'd256);
    chk("wrap_ovr", 32'(overrun_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fg_dac_writer.md
FG_DAC_WRITER -- requirements
Module: fg_dac_writer

Interface
REQ-001 SHALL have parameter BITWIDTH, default 8, meaning sample and DAC data width.
REQ-002 SHALL have parameter SETUP_CYCLES, default 1, range 1..15, meaning data-stable cycles before the WR low phase.
REQ-003 SHALL have parameter WR_LOW_CYCLES, default 2, range 1..15, meaning cycles dac_wr_n_o is held low.
REQ-004 SHALL have parameter HOLD_CYCLES, default 1, range 1..15, meaning data-stable cycles after the WR low phase.
REQ-005 SHALL have parameter CLR_CYCLES, default 4, range 1..15, meaning cycles dac_clr_n_o stays low after reset release.
REQ-006 SHALL have port clk_i, input, 1 bit: the single clock; all logic on the rising edge.
REQ-007 SHALL have port rstn_i, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port enable_i, input, 1 bit: output enable from the configuration.
REQ-009 SHALL have port data_i, input, BITWIDTH bits: sample from the function generator.
REQ-010 SHALL have port valid_i, input, 1 bit: single-cycle strobe qualifying data_i.
REQ-011 SHALL have port ovr_clr_i, input, 1 bit: clears the sticky overrun flag.
REQ-012 SHALL have port dac_data_o, output, BITWIDTH bits: registered parallel DAC data bus.
REQ-013 SHALL have port dac_wr_n_o, output, 1 bit: active-low DAC write strobe.
REQ-014 SHALL have port dac_clr_n_o, output, 1 bit: active-low DAC clear.
REQ-015 SHALL have port dac_pd_n_o, output, 1 bit: active-low DAC power-down.
REQ-016 SHALL have port busy_o, output, 1 bit: high whenever the state is not IDLE.
REQ-017 SHALL have port overrun_o, output, 1 bit: sticky flag indicating a sample was dropped.
REQ-018 SHALL have port wr_count_o, output, 8 bits: count of completed writes, wrapping 255 -> 0.

Function
REQ-019 SHALL implement the states CLEAR, IDLE, SETUP, WRITE and HOLD, with a 4-bit phase counter.
REQ-020 SHALL, in CLEAR, drive dac_clr_n_o=0 for CLR_CYCLES cycles after reset release, ignore valid_i, then go to IDLE.
REQ-021 SHALL, in IDLE, when valid_i=1 and enable_i=1, load data_i into dac_data_o on that edge and go to SETUP.
REQ-022 SHALL hold dac_wr_n_o=1 for SETUP_CYCLES cycles in SETUP, 0 for WR_LOW_CYCLES cycles in WRITE, and 1 for HOLD_CYCLES cycles in HOLD.
REQ-023 SHALL keep dac_data_o constant from entry to SETUP through the last HOLD cycle.
REQ-024 SHALL increment wr_count_o by 1 on the WRITE -> HOLD transition.
REQ-025 SHALL, when valid_i=1 and enable_i=1 in SETUP/WRITE/HOLD, store data_i in a one-entry pending buffer.
REQ-026 SHALL, on a strobe arriving while the pending buffer is already full, overwrite the buffer with the newer data_i and set overrun_o.
REQ-027 SHALL, at the end of HOLD, load dac_data_o and go to SETUP if valid_i=1 or pending is full, otherwise go to IDLE.
REQ-028 SHALL, at the end of HOLD, give valid_i priority over pending (pending discarded, overrun_o set) when both are present.
REQ-029 SHALL, on the cycle the pending entry is consumed, mark the buffer empty.
REQ-030 SHALL ignore valid_i when enable_i=0, clear pending, and let any write in progress complete normally.
REQ-031 SHALL drive dac_pd_n_o = 0 only when enable_i=0 and state is IDLE, registered (one-cycle latency), else 1.
REQ-032 SHALL clear overrun_o on ovr_clr_i=1, with a same-cycle set taking priority over clear.
REQ-033 SHALL give a latency of one edge from the valid_i sample to new dac_data_o, and SETUP_CYCLES further edges to the dac_wr_n_o fall.
REQ-034 SHALL sustain a maximum throughput of one write per SETUP_CYCLES+WR_LOW_CYCLES+HOLD_CYCLES cycles (4 with defaults).
REQ-035 SHALL make all outputs registered and free of glitches.

Reset
REQ-036 SHALL, while rstn_i=0, asynchronously force state=CLEAR, dac_data_o=0, dac_wr_n_o=1, dac_clr_n_o=0, dac_pd_n_o=1, busy_o=1, overrun_o=0, wr_count_o=0, and pending empty.
REQ-037 SHALL, on a reset asserted mid-write, raise dac_wr_n_o immediately, discard the sample, and restart in CLEAR with its full CLR_CYCLES sequence on release.

Verification
REQ-038 SHALL verify clear: release reset, pulse valid_i in cycle 2 -> dac_clr_n_o low for exactly 4 cycles, sample ignored, wr_count_o=0.
REQ-039 SHALL verify a single write: enable=1, valid with data 0xA5 -> dac_data_o=0xA5 next edge, dac_wr_n_o low at edges +2..+3, wr_count_o=1, IDLE after 4 cycles.
REQ-040 SHALL verify back-to-back: strobes 0x11, then 0x22 two cycles later -> 0x11 then 0x22 written, 4 cycles apart, overrun_o=0, wr_count_o=2.
REQ-041 SHALL verify overrun: strobes 0x01, 0x02, 0x03 on consecutive cycles -> writes 0x01 then 0x03, overrun_o=1 until ovr_clr_i.
REQ-042 SHALL verify disable: enable_i dropped during WRITE with pending 0x44 -> current write completes, 0x44 is never written, dac_pd_n_o=0 one cycle after IDLE.
REQ-043 SHALL verify wrap and reset: 256 writes -> wr_count_o=0; reset in WRITE -> dac_wr_n_o=1 immediately, all outputs at reset values.
